// File: rtl/csi_frame_sender.sv
// Holds one frame of CSI (NSC subcarriers x 3 antennas, signed mag/phase) and
// replays it per subcarrier; CSI_done is registered one cycle after the words settle.
module csi_frame_sender #(
  parameter int NSC = 30,
  parameter int W   = 20,
  parameter int GAP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [4:0]          wr_sc,
  input  logic [1:0]          wr_ant,
  input  logic signed [W-1:0] wr_mag,
  input  logic signed [W-1:0] wr_ph,
  input  logic                start,
  input  logic                loop,
  output logic                busy,
  output logic                wr_err,
  output logic                CSI_done,
  output logic signed [W-1:0] M1,
  output logic signed [W-1:0] M2,
  output logic signed [W-1:0] M3,
  output logic signed [W-1:0] P1,
  output logic signed [W-1:0] P2,
  output logic signed [W-1:0] P3,
  output logic [4:0]          sc_idx,
  output logic                frame_done
);

  localparam int         DEPTH      = NSC * 3;
  localparam int         AW         = $clog2(DEPTH);
  localparam logic [4:0] LAST_SC    = 5'(NSC - 1);
  localparam logic [3:0] GAP_RELOAD = 4'(GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_STROBE,
    S_GAP
  } state_t;

  state_t              state_q, state_d;
  logic [4:0]          sc_q, sc_d;
  logic [3:0]          gap_q, gap_d;
  logic [4:0]          sc_idx_q, sc_idx_d;
  logic                csi_done_q, csi_done_d;
  logic                frame_done_q, frame_done_d;
  logic                wr_err_q, wr_err_d;
  logic signed [W-1:0] mag_q [3];
  logic signed [W-1:0] mag_d [3];
  logic signed [W-1:0] ph_q  [3];
  logic signed [W-1:0] ph_d  [3];

  logic signed [W-1:0] mag_mem_q [DEPTH];
  logic signed [W-1:0] ph_mem_q  [DEPTH];
  logic                wr_ok;

  function automatic logic [AW-1:0] entry_addr(input logic [4:0] sc, input logic [1:0] ant);
    int a;
    a = 3 * int'(sc) + int'(ant);
    return a[AW-1:0];
  endfunction

  // Writes are only taken while idle so a frame in flight never sees torn data.
  assign wr_ok = wr_en && (state_q == S_IDLE) && (int'(wr_sc) < NSC) && (wr_ant != 2'd3);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mag_mem_q[entry_addr(wr_sc, wr_ant)] <= wr_mag;
      ph_mem_q[entry_addr(wr_sc, wr_ant)]  <= wr_ph;
    end
  end

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    gap_d        = gap_q;
    sc_idx_d     = sc_idx_q;
    csi_done_d   = 1'b0;
    frame_done_d = 1'b0;
    wr_err_d     = wr_en && !wr_ok;
    for (int a = 0; a < 3; a++) begin
      mag_d[a] = mag_q[a];
      ph_d[a]  = ph_q[a];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          sc_d    = 5'd0;
        end
      end
      S_LOAD: begin
        for (int a = 0; a < 3; a++) begin
          mag_d[a] = mag_mem_q[entry_addr(sc_q, 2'(a))];
          ph_d[a]  = ph_mem_q[entry_addr(sc_q, 2'(a))];
        end
        sc_idx_d = sc_q;
        state_d  = S_STROBE;
      end
      S_STROBE: begin
        // Strobe is registered, so it lands one cycle after the words changed.
        csi_done_d = 1'b1;
        gap_d      = GAP_RELOAD;
        state_d    = S_GAP;
      end
      S_GAP: begin
        if (gap_q != 4'd0) begin
          gap_d = gap_q - 4'd1;
        end else if (sc_q != LAST_SC) begin
          sc_d    = sc_q + 5'd1;
          state_d = S_LOAD;
        end else begin
          frame_done_d = 1'b1;
          sc_d         = 5'd0;
          state_d      = loop ? S_LOAD : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sc_q         <= 5'd0;
      gap_q        <= 4'd0;
      sc_idx_q     <= 5'd0;
      csi_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
      for (int a = 0; a < 3; a++) begin
        mag_q[a] <= '0;
        ph_q[a]  <= '0;
      end
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      gap_q        <= gap_d;
      sc_idx_q     <= sc_idx_d;
      csi_done_q   <= csi_done_d;
      frame_done_q <= frame_done_d;
      wr_err_q     <= wr_err_d;
      for (int a = 0; a < 3; a++) begin
        mag_q[a] <= mag_d[a];
        ph_q[a]  <= ph_d[a];
      end
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign wr_err     = wr_err_q;
  assign CSI_done   = csi_done_q;
  assign frame_done = frame_done_q;
  assign sc_idx     = sc_idx_q;
  assign M1         = mag_q[0];
  assign M2         = mag_q[1];
  assign M3         = mag_q[2];
  assign P1         = ph_q[0];
  assign P2         = ph_q[1];
  assign P3         = ph_q[2];

endmodule

// File: doc/csi_frame_sender.md
# csi_frame_sender

Transmit-side counterpart of the CSI consumer controller. Holds one frame of channel-state information (30 subcarriers × 3 antennas, signed 20-bit magnitude and phase per entry) and replays it one subcarrier at a time. For each subcarrier it drives the six M/P words, then a single-cycle `CSI_done` strobe once the words are stable. Sits between the CSI capture/test-pattern source and the controller, and is used both in the datapath and as the controller's bench stimulus.

## Interface
Parameters:
- `NSC`, 30: subcarriers per frame; index range 0..NSC-1.
- `W`, 20: width of each magnitude/phase word, signed.
- `GAP`, 2: cycles `CSI_done` stays low after each strobe before the next subcarrier is loaded; legal range 1..15.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: buffer write strobe.
- `wr_sc` input 5: subcarrier index of the write.
- `wr_ant` input 2: antenna 0..2 of the write.
- `wr_mag` input W: signed magnitude to store.
- `wr_ph` input W: signed phase to store.
- `start` input 1: launch frame transmission; honoured only in IDLE.
- `loop` input 1: sampled at frame end; 1 = restart at subcarrier 0 without passing through IDLE.
- `busy` output 1: high in every state except IDLE.
- `wr_err` output 1: one-cycle pulse when a write is dropped.
- `CSI_done` output 1: one-cycle strobe; M/P words are valid and stable across it.
- `M1`, `M2`, `M3` output W: magnitude of antennas 0/1/2 for the current subcarrier, signed.
- `P1`, `P2`, `P3` output W: phase of antennas 0/1/2 for the current subcarrier, signed.
- `sc_idx` output 5: subcarrier currently on M/P.
- `frame_done` output 1: one-cycle pulse after the last subcarrier's gap completes.

## Operation
- **Buffer:** NSC×3 entries of {mag, ph}. Reset does not clear it; contents are undefined until written.
- **Writes:**
  - Accepted when `wr_en`=1, `busy`=0, `wr_sc`<NSC and `wr_ant`≤2.
  - Otherwise the write is dropped and `wr_err` pulses in the next cycle.
  - A write in the same cycle as `start` while in IDLE is accepted and is visible to that frame.
- **FSM** states: IDLE, LOAD, STROBE, GAP.
  - IDLE: `start`=1 → LOAD with sc=0.
  - LOAD: register the buffer entries for sc onto M1..P3, set `sc_idx`=sc, then go to STROBE.
  - STROBE: `CSI_done`=1 for exactly this state, then go to GAP and load the gap counter with GAP-1.
  - GAP: count down to 0. At 0:
    - if sc<NSC-1: sc+1 → LOAD;
    - otherwise pulse `frame_done`; then `loop`=1 → LOAD with sc=0, `loop`=0 → IDLE.
- **Start handling:** `start` is ignored in any state other than IDLE; it is not queued.
- **Output hold:** M1..P3 and `sc_idx` hold their values from one LOAD until the next LOAD, including while IDLE after a frame.
- **Wrap:** after sc=NSC-1 the index wraps to 0; it never takes the value NSC.
- **Mid-frame reset:** `rst` at any cycle forces IDLE in the next cycle. All outputs return to reset values and no further strobes occur.

## Timing
- **Reset values:** `busy`, `wr_err`, `CSI_done`, `frame_done` = 0; M1..P3 = 0; `sc_idx` = 0; state IDLE.
- **Frame start:** with `start` high in cycle t, `busy`=1 from t+1.
  - M/P for sc0 are valid from t+2.
  - `CSI_done`=1 in cycle t+3 only, giving one full cycle of data setup before the rising edge.
- **Subcarrier period:** 2+GAP cycles; a frame is NSC·(2+GAP) cycles (120 with defaults).
- **Strobe spacing:** `CSI_done` low time between strobes is GAP+1 cycles; it is never high in two consecutive cycles.
- **Frame end:** `frame_done` is high in the cycle after the last GAP count.
  - With `loop`=0, `busy` falls in that same cycle.
  - With `loop`=1, that cycle is the LOAD of sc0.
- **Write error timing:** `wr_err` is asserted in the cycle after the offending write.
- **Busy boundaries:** a write issued in the cycle `busy` rises is dropped. A write issued in the cycle `busy` falls is accepted.

## Test plan
- **Full frame:** write every entry with mag = sc·4+ant and ph = −(sc·4+ant), then pulse `start`.
  - Expect 30 `CSI_done` pulses, 4 cycles apart.
  - At strobe k: M2=4k+1, P3=−(4k+2), `sc_idx`=k.
  - `frame_done` 120 cycles after `busy` rises.
- **Illegal writes:** write with `wr_sc`=30, then with `wr_ant`=3, then while busy.
  - Expect a `wr_err` pulse for each and the buffer unchanged (replayed values identical to the prior frame).
- **Start while busy:** pulse `start` mid-frame.
  - Expect no restart, `sc_idx` sequence unbroken, exactly 30 strobes.
- **Loop:** hold `loop`=1.
  - Expect the strobe after sc29 to carry sc0 data 4 cycles after the sc29 strobe, with `busy` never dropping.
  - Drop `loop`; expect return to IDLE after that frame.
- **Mid-frame reset:** assert `rst` at sc=12 while in GAP.
  - Expect next-cycle `busy`=0, M1..P3=0, `sc_idx`=0, and no `CSI_done` until a new `start`.
- **GAP=1 build:** run a full frame.
  - Expect a 3-cycle strobe period and a 90-cycle frame, with `CSI_done` never high in adjacent cycles.
